adder_32bit_r: RTL and testbench



---
 rtl/adder_32bit_r.sv | 87 ++++++++
 tb/tb_adder_32bit_r.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/adder_32bit_r.sv
// Registered 32-bit two's-complement adder with carry-in, carry-out and
// signed-overflow flag. The integer add datapath for the MiniMIPS ALU.
// The combinational core is built from eight 4-bit carry-lookahead groups
// whose group carries ripple from one group to the next. Sum and flags
// are registered together so downstream logic always samples a coherent
// result one cycle after the operands.
module adder_32bit_r (
    input  logic [31:0] value1,
    input  logic [31:0] value2,
    output logic [31:0] sum,
    output logic        carry_out,
    input  logic        carry_in,
    output logic        overflow,
    input  logic        clk,
    input  logic        reset_n
);

    localparam int unsigned NUM_GROUPS = 8;
    localparam int unsigned GROUP_W    = 4;

    logic [31:0] w_g;        // per-bit generate
    logic [31:0] w_p;        // per-bit propagate
    logic [32:0] w_c;        // w_c[i] is the carry into bit i; w_c[32] is c32
    logic [31:0] w_sum;
    logic        w_overflow;

    logic [31:0] r_sum;
    logic        r_carry_out;
    logic        r_overflow;

    assign w_g = value1 & value2;
    assign w_p = value1 ^ value2;

    // Carry network: 4-bit lookahead inside each group, ripple between groups.
    always_comb begin
        // NOTE: every bit gets a default first so no path leaves w_c unassigned (no latch).
        w_c    = '0;
        w_c[0] = carry_in;
        for (int k = 0; k < NUM_GROUPS; k++) begin
            int unsigned b;
            logic        ci;
            logic [3:0]  g;
            logic [3:0]  p;
            b  = k * GROUP_W;
            ci = w_c[b];
            g  = w_g[b +: GROUP_W];
            p  = w_p[b +: GROUP_W];
            w_c[b + 1] = g[0]
                       | (p[0] & ci);
            w_c[b + 2] = g[1]
                       | (p[1] & g[0])
                       | (p[1] & p[0] & ci);
            w_c[b + 3] = g[2]
                       | (p[2] & g[1])
                       | (p[2] & p[1] & g[0])
                       | (p[2] & p[1] & p[0] & ci);
            w_c[b + 4] = g[3]
                       | (p[3] & g[2])
                       | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0])
                       | (p[3] & p[2] & p[1] & p[0] & ci);
        end
    end

    // Sum bits and signed overflow (carry into bit 31 vs carry out of bit 31).
    assign w_sum      = w_p ^ w_c[31:0];
    assign w_overflow = w_c[31] ^ w_c[32];

    // Output register: captures sum and flags together; cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all three registers update from the same pre-edge values.
            r_sum       <= w_sum;
            r_carry_out <= w_c[32];
            r_overflow  <= w_overflow;
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_adder_32bit_r.sv
// Self-checking bench for adder_32bit_r: directed vector table applied on
// consecutive edges, reset and input-hold sequences, and a random sweep
// against a 33-bit reference model.
module tb_adder_32bit_r;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_co;
        logic        exp_ov;
    } vec_t;

    logic [31:0] value1;
    logic [31:0] value2;
    logic        carry_in;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        clk;
    logic        reset_n;

    int n_checks;
    int n_fail;

    vec_t vecs[11];

    adder_32bit_r dut (
        .value1    (value1),
        .value2    (value2),
        .sum       (sum),
        .carry_out (carry_out),
        .carry_in  (carry_in),
        .overflow  (overflow),
        .clk       (clk),
        .reset_n   (reset_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] es, input logic eco, input logic eov);
        check({name, ".sum"}, sum, es);
        check({name, ".carry_out"}, {31'b0, carry_out}, {31'b0, eco});
        check({name, ".overflow"}, {31'b0, overflow}, {31'b0, eov});
    endtask

    initial begin
        logic [32:0] ref_full;
        logic        ref_ov;
        n_checks = 0;
        n_fail   = 0;

        // Directed vectors with hand-computed results.
        vecs[0]  = '{32'd100000,     32'd200000,     1'b1, 32'h000493E1, 1'b0, 1'b0};
        vecs[1]  = '{32'h80000000,   32'h7FFFFFFF,   1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{32'h12345678,   32'h87654321,   1'b0, 32'h99999999, 1'b0, 1'b0};
        vecs[3]  = '{32'h7FFFFFFF,   32'h00000001,   1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5]  = '{32'hFFFFFFFF,   32'h00000000,   1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{32'h7FFFFFFF,   32'h00000000,   1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[7]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000000F,   32'h00000001,   1'b0, 32'h00000010, 1'b0, 1'b0};
        vecs[9]  = '{32'h0FFFFFFF,   32'h00000001,   1'b0, 32'h10000000, 1'b0, 1'b0};
        vecs[10] = '{32'h00000000,   32'h00000000,   1'b0, 32'h00000000, 1'b0, 1'b0};

        value1   = 32'h0;
        value2   = 32'h0;
        carry_in = 1'b0;
        reset_n  = 1'b0;

        // Reset state with inputs that would otherwise produce a nonzero sum.
        value1 = 32'h11111111;
        value2 = 32'h22222222;
        #1;
        check_out("reset_initial", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_hold_edge", 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;

        // Table vectors on consecutive edges; before each edge the previous
        // result must still be present, after it the new one.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            value1   = vecs[i].a;
            value2   = vecs[i].b;
            carry_in = vecs[i].cin;
            #1;
            if (i > 0)
                check_out($sformatf("vec%0d_pre_edge", i), vecs[i-1].exp_sum, vecs[i-1].exp_co, vecs[i-1].exp_ov);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_co, vecs[i].exp_ov);
        end

        // Mid-cycle input change has no effect until the next edge.
        @(negedge clk);
        value1   = 32'h7FFFFFFF;
        value2   = 32'h00000001;
        carry_in = 1'b0;
        @(posedge clk);
        #1;
        check_out("hold_base", 32'h80000000, 1'b0, 1'b1);
        value1   = 32'h00000005;
        value2   = 32'h00000003;
        carry_in = 1'b1;
        #3;
        check_out("hold_mid_cycle", 32'h80000000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_out("hold_next_edge", 32'h00000009, 1'b0, 1'b0);

        // Mid-cycle async reset with nonzero registered outputs and in-flight inputs.
        value1   = 32'h80000000;
        value2   = 32'hFFFFFFFF;
        carry_in = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_out("reset_async", 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_held", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n  = 1'b1;
        value1   = 32'h12345678;
        value2   = 32'h87654321;
        carry_in = 1'b1;
        #1;
        check_out("reset_release_pre_edge", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_first_edge", 32'h9999999A, 1'b0, 1'b0);

        // Random sweep against a 33-bit reference.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            value1   = $urandom;
            value2   = $urandom;
            carry_in = 1'($urandom_range(0, 1));
            ref_full = {1'b0, value1} + {1'b0, value2} + {32'b0, carry_in};
            ref_ov   = (value1[31] == value2[31]) && (ref_full[31] != value1[31]);
            @(posedge clk);
            #1;
            check_out($sformatf("rand%0d", i), ref_full[31:0], ref_full[32], ref_ov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
